muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle sequencer that owns HI/LO updates. It replaces the per-op combinational mult/multu/div/divu
//   units with one shared iterative datapath. It accepts a MULT/MULTU/DIV/DIVU/MTHI/MTLO op from the
//   controller and stalls the PC and regfile write while iterating. It then issues a single HI/LO write
//   pulse. It sits between controller/regfile (rs/rt data) and the HI/LO registers; cpu drives PC_ENA = ~stall.
// PARAMETERS
//   WIDTH   32   operand width; iteration count = WIDTH
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high
//   op_valid    in   1      op field valid this cycle
//   op          in   3      000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//   rs_data     in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//   rt_data     in   WIDTH  multiplier / divisor
//   flush       in   1      exception/ERET abort; same effect as reset for this block
//   stall       out  1      hold PC and suppress RF_W
//   busy        out  1      state != IDLE
//   hi_we       out  1      HI write pulse
//   lo_we       out  1      LO write pulse
//   hi_wdata    out  WIDTH  HI data; meaningful only while hi_we=1
//   lo_wdata    out  WIDTH  LO data; meaningful only while lo_we=1
//   div_by_zero out  1      one-cycle pulse for DIV/DIVU with rt=0
// BEHAVIOUR
//   - Reset/flush (sync): state=IDLE, counter=0. stall, busy, hi_we, lo_we and div_by_zero are 0.
//     hi_wdata and lo_wdata are 0. Reset/flush wins over any op and aborts with no HI/LO write.
//   - FSM states: IDLE, RUN, FIX, DONE.
//   - IDLE, op_valid, mul/div op (cycle T):
//     - stall=1 combinationally.
//     - Operands are captured as |x| for signed ops, raw for unsigned ops.
//     - Sign flags are latched; counter is set to WIDTH-1; next state is RUN.
//   - IDLE, DIV/DIVU with rt=0: next state is DONE with no write; div_by_zero pulses at T+1.
//   - IDLE, MTHI/MTLO: no stall. hi_we/lo_we=1 in the same cycle with wdata=rs_data; stay IDLE.
//   - RUN: one radix-2 step per cycle.
//     - Multiply: shift-add into a 2*WIDTH accumulator.
//     - Divide: restoring shift-subtract.
//     - Counter decrements each step; at 0, go to FIX. Occupies T+1..T+32.
//   - FIX (T+33): signed correction.
//     - Product is negated if the operand signs differ.
//     - Quotient is negated if the signs differ; remainder takes the dividend's sign.
//   - DONE (T+34): stall=0, hi_we=lo_we=1 with the final results; next state is IDLE.
//     - op_valid in DONE is ignored, because it is the same instruction retiring.
//   - Stall is high T..T+33 (34 cycles); total occupancy is 35 cycles.
//   - Results: MULT/MULTU give HI=prod[2W-1:W], LO=prod[W-1:0]; DIV/DIVU give LO=quotient, HI=remainder.
//   - Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0 (two's-complement wrap); no flag.
//   - Arithmetic is full-width unsigned internally; all negation is two's complement mod 2^WIDTH.
//   - op_valid with op=NONE or an undefined code is ignored.
// STRUCTURE
//   - muldiv_defs.vh holds the op encodings and FSM state localparams. The controller decoder uses the same file.
//   - Sub-module muldiv_iter_core holds the accumulator/remainder registers and one step of shift-add or
//     shift-subtract. muldiv_sequencer holds the FSM, counter, sign handling and handshake.
// TESTING
//   1. MULTU 0xFFFFFFFF*0xFFFFFFFF at T -> stall high T..T+33; at T+34 HI=0xFFFFFFFE, LO=0x00000001, we pulses.
//   2. MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x7FFFFFFF*0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
//   3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//   4. DIVU 5/0 at T -> stall only at T; div_by_zero=1 at T+1; hi_we=lo_we=0 throughout; IDLE at T+2.
//   5. reset (then flush) at T+10 during DIV -> IDLE next cycle, stall=0, no we pulse.
//      Then MTHI 0x1234 -> hi_we=1, hi_wdata=0x1234 in the same cycle, no stall.
//   6. Back-to-back: MULT held through DONE then DIVU issued at T+35 -> exactly one write per op; second result at T+69.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for the HI/LO mul/div sequencer.
package muldiv_sequencer_pkg;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared radix-2 datapath: {hi,lo} accumulator that does one shift-add (multiply)
// or one restoring shift-subtract (divide) step per enabled cycle.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 is_div_i,
  input  logic [WIDTH-1:0]     low_i,
  input  logic [WIDTH-1:0]     opb_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q;
  logic               div_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    // Shifted remainder is below 2*divisor, so the subtracted value always fits in WIDTH bits.
    div_fits  = div_shift[WIDTH] || (div_shift[WIDTH-1:0] >= opb_q);
    if (div_q) begin
      if (div_fits) acc_d = {div_shift[WIDTH-1:0] - opb_q, acc_q[WIDTH-2:0], 1'b1};
      else          acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, low_i};
      opb_q <= opb_i;
      div_q <= is_div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: FSM, step counter, sign handling and stall/write handshake around
// the shared iterative mul/div core.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_a_q, neg_b_q, div_q, we_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               abort, idle, launch, op_div, div_zero, mthi_now, mtlo_now;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [2*WIDTH-1:0] acc, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_d, lo_d;

  assign abort    = reset | flush;
  assign idle     = (state_q == ST_IDLE);
  assign launch   = idle & op_valid & is_arith_op(op) & ~abort;
  assign op_div   = is_div_op(op);
  assign div_zero = op_div & (rt_data == '0);
  assign mthi_now = idle & op_valid & (op == OP_MTHI) & ~abort;
  assign mtlo_now = idle & op_valid & (op == OP_MTLO) & ~abort;

  assign rs_neg = is_signed_op(op) & rs_data[WIDTH-1];
  assign rt_neg = is_signed_op(op) & rt_data[WIDTH-1];
  assign rs_abs = rs_neg ? -rs_data : rs_data;
  assign rt_abs = rt_neg ? -rt_data : rt_data;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .clear_i  (abort),
    .load_i   (launch & ~div_zero),
    .step_i   (state_q == ST_RUN),
    .is_div_i (op_div),
    .low_i    (rs_abs),
    .opb_i    (rt_abs),
    .acc_o    (acc)
  );

  // Remainder follows the dividend's sign; quotient/product follow the sign product.
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc : acc;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_d     = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    lo_d     = div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (abort) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div_q   <= 1'b0;
      we_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          we_q <= 1'b0;
          dz_q <= 1'b0;
          if (launch) begin
            neg_a_q <= rs_neg;
            neg_b_q <= rt_neg;
            div_q   <= op_div;
            if (div_zero) begin
              dz_q    <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cnt_q   <= CNT_W'(WIDTH - 1);
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) state_q <= ST_FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          we_q    <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          we_q    <= 1'b0;
          dz_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall       = launch | (state_q == ST_RUN) | (state_q == ST_FIX);
  assign busy        = ~idle;
  assign hi_we       = we_q | mthi_now;
  assign lo_we       = we_q | mtlo_now;
  assign hi_wdata    = mthi_now ? rs_data : hi_q;
  assign lo_wdata    = mtlo_now ? rs_data : lo_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed HI/LO results and timing.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, op_valid, flush;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        stall, busy, hi_we, lo_we, div_by_zero;
  logic [31:0] hi_wdata, lo_wdata;

  int passed = 0;
  int total  = 0;

  localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011, DIVU = 3'b100;
  localparam logic [2:0] MTHI = 3'b101, MTLO = 3'b110;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .hi_wdata    (hi_wdata),
    .lo_wdata    (lo_wdata),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one arithmetic op at cycle T and watches T..T+40.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int first, stalls, wes, lowes;
    logic [31:0] h, l;
    first = -1; stalls = 0; wes = 0; lowes = 0; h = '0; l = '0;
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (lo_we) lowes++;
      if (hi_we) begin
        wes++;
        if (first < 0) begin first = k; h = hi_wdata; l = lo_wdata; end
      end
      next_cycle();
      op_valid = 1'b0;
    end
    chk({tag, " write_cycle"}, 64'(first), 64'(34));
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(34));
    chk({tag, " hi_we_count"}, 64'(wes), 64'(1));
    chk({tag, " lo_we_count"}, 64'(lowes), 64'(1));
    chk({tag, " hi"}, 64'(h), 64'(eh));
    chk({tag, " lo"}, 64'(l), 64'(el));
  endtask

  task automatic abort_run(input string tag, input logic use_flush);
    int wes;
    wes = 0;
    op_valid = 1'b1; op = DIV; rs_data = 32'd100; rt_data = 32'd3;
    next_cycle();
    op_valid = 1'b0;
    repeat (9) next_cycle();
    if (use_flush) flush = 1'b1;
    else           reset = 1'b1;
    next_cycle();
    reset = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk({tag, " busy_after"}, 64'(busy), 64'(0));
    chk({tag, " stall_after"}, 64'(stall), 64'(0));
    for (int k = 0; k < 40; k++) begin
      if (hi_we || lo_we) wes++;
      @(negedge clk);
    end
    chk({tag, " no_write"}, 64'(wes), 64'(0));
    next_cycle();
  endtask

  task automatic back_to_back();
    int wes, c1, c2;
    logic [31:0] h1, l1, h2, l2;
    wes = 0; c1 = -1; c2 = -1; h1 = '0; l1 = '0; h2 = '0; l2 = '0;
    op_valid = 1'b1; op = MULT; rs_data = 32'd6; rt_data = 32'hFFFF_FFF9;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (hi_we) begin
        if (wes == 0) begin c1 = k; h1 = hi_wdata; l1 = lo_wdata; end
        else if (wes == 1) begin c2 = k; h2 = hi_wdata; l2 = lo_wdata; end
        wes++;
      end
      next_cycle();
      if (k == 34) begin op = DIVU; rs_data = 32'd100; rt_data = 32'd7; end
      if (k == 35) op_valid = 1'b0;
    end
    chk("b2b write_count", 64'(wes), 64'(2));
    chk("b2b first_cycle", 64'(c1), 64'(34));
    chk("b2b second_cycle", 64'(c2), 64'(69));
    chk("b2b mult_hi", 64'(h1), 64'h0000_0000_FFFF_FFFF);
    chk("b2b mult_lo", 64'(l1), 64'h0000_0000_FFFF_FFD6);
    chk("b2b divu_hi", 64'(h2), 64'd2);
    chk("b2b divu_lo", 64'(l2), 64'd14);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'b000; rs_data = '0; rt_data = '0;
    next_cycle();
    op_valid = 1'b1; op = MULT; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    chk("rst stall", 64'(stall), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst hi_we", 64'(hi_we), 64'(0));
    chk("rst lo_we", 64'(lo_we), 64'(0));
    chk("rst dz", 64'(div_by_zero), 64'(0));
    chk("rst hi_wdata", 64'(hi_wdata), 64'(0));
    chk("rst lo_wdata", 64'(lo_wdata), 64'(0));
    next_cycle();
    op_valid = 1'b0;
    reset = 1'b0;

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_maxpos", MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    run_op("div_negdvd", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negdvs", DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_small", DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    op_valid = 1'b1; op = 3'b111; rs_data = 32'h55; rt_data = 32'h3;
    @(negedge clk);
    chk("undef stall", 64'(stall), 64'(0));
    chk("undef we", 64'({hi_we, lo_we}), 64'(0));
    next_cycle();
    op = 3'b000;
    @(negedge clk);
    chk("undef busy", 64'(busy), 64'(0));
    next_cycle();
    op_valid = 1'b0;

    op_valid = 1'b1; op = DIVU; rs_data = 32'd5; rt_data = 32'd0;
    @(negedge clk);
    chk("dz stall_T", 64'(stall), 64'(1));
    chk("dz flag_T", 64'(div_by_zero), 64'(0));
    chk("dz we_T", 64'({hi_we, lo_we}), 64'(0));
    next_cycle();
    op_valid = 1'b0;
    @(negedge clk);
    chk("dz flag_T1", 64'(div_by_zero), 64'(1));
    chk("dz stall_T1", 64'(stall), 64'(0));
    chk("dz we_T1", 64'({hi_we, lo_we}), 64'(0));
    next_cycle();
    @(negedge clk);
    chk("dz busy_T2", 64'(busy), 64'(0));
    chk("dz flag_T2", 64'(div_by_zero), 64'(0));
    chk("dz we_T2", 64'({hi_we, lo_we}), 64'(0));
    next_cycle();

    abort_run("reset_abort", 1'b0);
    abort_run("flush_abort", 1'b1);

    op_valid = 1'b1; op = MTHI; rs_data = 32'h0000_1234;
    @(negedge clk);
    chk("mthi hi_we", 64'(hi_we), 64'(1));
    chk("mthi hi_wdata", 64'(hi_wdata), 64'h1234);
    chk("mthi lo_we", 64'(lo_we), 64'(0));
    chk("mthi stall", 64'(stall), 64'(0));
    next_cycle();
    op = MTLO; rs_data = 32'h0000_ABCD;
    @(negedge clk);
    chk("mtlo lo_we", 64'(lo_we), 64'(1));
    chk("mtlo lo_wdata", 64'(lo_wdata), 64'hABCD);
    chk("mtlo hi_we", 64'(hi_we), 64'(0));
    next_cycle();
    op_valid = 1'b0;
    @(negedge clk);
    chk("mt busy", 64'(busy), 64'(0));
    next_cycle();

    back_to_back();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
